alu_control: RTL and testbench

- Microsequencer that drives the control inputs of the core ALU and collects its carry/overflow results.
- Sits between instruction decode and the ALU/bus fabric: takes a one-cycle command (operation, destination, carry, decimal flag) and sequences LOAD → [DECIMAL] → STORE on PHI2.
- Asserts the input-select, operation-select, carry-in, decimal-adjust and bus-transfer lines the ALU consumes, then returns ACR/AVR as flag updates.

---
 rtl/alu_control.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
//   Microsequencer that drives the control inputs of the core ALU. A one-cycle
//   command (operation, destination, carry, decimal flag) is sequenced through
//   LOAD -> [DECIMAL] -> STORE, and the ALU carry/overflow results are captured
//   at the end of STORE as processor flag updates. Every output is registered.
//
// Parameters
//   DEC_EN    1: decimal ADC/SBC insert a DECIMAL cycle and drive n_DAA/n_DSA;
//             0: n_DAA/n_DSA stay high and no extra cycle is inserted.
//
// Ports
//   PHI2      clock, rising edge
//   RES       synchronous active-high reset
//   START     command strobe (accepted in IDLE or STORE)
//   OPSEL     0 ADC,1 SBC,2 AND,3 ORA,4 EOR,5 ASL,6 LSR,7 ROL,8 ROR,9 INC,10 CMP
//   DST       result destination: 0 accumulator (SB_AC), 1 data bus (SB_DB)
//   C_IN      processor carry flag
//   D_IN      processor decimal flag
//   ACR/AVR   ALU carry / overflow results
//   ADDSEL    {NDB_ADD, DB_ADD, Z_ADD, SB_ADD} ALU input selects
//   OPS       {ANDS, EORS, ORS, SRS, SUMS} ALU operation select (one-hot or 0)
//   ADD_SB06/ADD_SB7  result bits 0-6 / bit 7 onto SB
//   SB_AC, AC_SB, SB_DB  bus transfer strobes
//   n_ACIN, n_DAA, n_DSA active-low carry-in and decimal adjust lines
//   ROR_B7    value for SB bit 7 during a ROR store
//   BUSY      command in progress
//   DONE      pulse in the STORE cycle
//   ERR       pulse for a START carrying an illegal OPSEL
//   C_OUT/V_OUT  captured carry / overflow
//   FLAG_WE   pulse in the STORE cycle; flags update at the end of it
// -----------------------------------------------------------------------------
module alu_control #(
  parameter bit DEC_EN = 1'b1
) (
  input  logic       PHI2,
  input  logic       RES,
  input  logic       START,
  input  logic [3:0] OPSEL,
  input  logic       DST,
  input  logic       C_IN,
  input  logic       D_IN,
  input  logic       ACR,
  input  logic       AVR,
  output logic [3:0] ADDSEL,
  output logic [4:0] OPS,
  output logic       ADD_SB06,
  output logic       ADD_SB7,
  output logic       SB_AC,
  output logic       AC_SB,
  output logic       SB_DB,
  output logic       n_ACIN,
  output logic       n_DAA,
  output logic       n_DSA,
  output logic       ROR_B7,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       C_OUT,
  output logic       V_OUT,
  output logic       FLAG_WE
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECIMAL, S_STORE} state_t;

  localparam logic [3:0] OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2,
                         OP_ORA = 4'd3, OP_EOR = 4'd4, OP_ASL = 4'd5,
                         OP_LSR = 4'd6, OP_ROL = 4'd7, OP_ROR = 4'd8,
                         OP_INC = 4'd9, OP_CMP = 4'd10;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_op;
  logic       r_dst, r_c, r_d;

  logic       w_can_accept, w_accept, w_err_nxt, w_dec_cycle;
  logic [3:0] w_op_nxt;
  logic       w_dst_nxt, w_c_nxt, w_d_nxt;
  logic       w_dec_add, w_dec_sub;

  logic [3:0] w_addsel;
  logic [4:0] w_ops;
  logic       w_add_sb06, w_add_sb7, w_sb_ac, w_ac_sb, w_sb_db;
  logic       w_n_acin, w_n_daa, w_n_dsa, w_ror_b7, w_done, w_flag_we;

  // Command acceptance and next state.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves a signal unassigned; an unassigned path infers a latch.
    w_can_accept = (r_state == S_IDLE) || (r_state == S_STORE);
    w_accept     = START && w_can_accept && (OPSEL <= OP_CMP);
    w_err_nxt    = START && w_can_accept && (OPSEL > OP_CMP);
    w_op_nxt     = w_accept ? OPSEL : r_op;
    w_dst_nxt    = w_accept ? DST   : r_dst;
    w_c_nxt      = w_accept ? C_IN  : r_c;
    w_d_nxt      = w_accept ? D_IN  : r_d;
    w_dec_cycle  = DEC_EN && r_d && ((r_op == OP_ADC) || (r_op == OP_SBC));

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = w_accept ? S_LOAD : S_IDLE;
      S_LOAD:    w_state_nxt = w_dec_cycle ? S_DECIMAL : S_STORE;
      S_DECIMAL: w_state_nxt = S_STORE;
      S_STORE:   w_state_nxt = w_accept ? S_LOAD : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode for the cycle being entered, so the registered outputs line
  // up with the registered state. It uses the command that will be latched.
  always_comb begin
    w_addsel   = '0;
    w_ops      = '0;
    w_add_sb06 = 1'b0;
    w_add_sb7  = 1'b0;
    w_sb_ac    = 1'b0;
    w_ac_sb    = 1'b0;
    w_sb_db    = 1'b0;
    w_n_acin   = 1'b1;
    w_n_daa    = 1'b1;
    w_n_dsa    = 1'b1;
    w_ror_b7   = 1'b0;
    w_done     = 1'b0;
    w_flag_we  = 1'b0;

    w_dec_add = DEC_EN && w_d_nxt && (w_op_nxt == OP_ADC);
    w_dec_sub = DEC_EN && w_d_nxt && (w_op_nxt == OP_SBC);

    // Decimal adjust lines are held for the whole command, LOAD to STORE.
    if (w_state_nxt != S_IDLE) begin
      w_n_daa = ~w_dec_add;
      w_n_dsa = ~w_dec_sub;
    end

    case (w_state_nxt)
      S_LOAD: begin
        case (w_op_nxt)
          OP_ADC: begin w_ac_sb = 1'b1; w_addsel = 4'b0101; w_ops = 5'b00001; w_n_acin = ~w_c_nxt; end
          OP_SBC: begin w_ac_sb = 1'b1; w_addsel = 4'b1001; w_ops = 5'b00001; w_n_acin = ~w_c_nxt; end
          OP_CMP: begin w_ac_sb = 1'b1; w_addsel = 4'b1001; w_ops = 5'b00001; w_n_acin = 1'b0; end
          OP_AND: begin w_ac_sb = 1'b1; w_addsel = 4'b0101; w_ops = 5'b10000; end
          OP_ORA: begin w_ac_sb = 1'b1; w_addsel = 4'b0101; w_ops = 5'b00100; end
          OP_EOR: begin w_ac_sb = 1'b1; w_addsel = 4'b0101; w_ops = 5'b01000; end
          OP_ASL: begin w_sb_db = 1'b1; w_addsel = 4'b0101; w_ops = 5'b00001; end
          OP_ROL: begin w_sb_db = 1'b1; w_addsel = 4'b0101; w_ops = 5'b00001; w_n_acin = ~w_c_nxt; end
          OP_LSR,
          OP_ROR: begin w_sb_db = 1'b1; w_addsel = 4'b0101; w_ops = 5'b00010; end
          OP_INC: begin w_sb_db = 1'b1; w_addsel = 4'b0011; w_ops = 5'b00001; w_n_acin = 1'b0; end
          default: ;
        endcase
      end
      S_STORE: begin
        w_done    = 1'b1;
        w_flag_we = 1'b1;
        // CMP only produces flags; its result never reaches a register.
        if (w_op_nxt != OP_CMP) begin
          w_add_sb06 = 1'b1;
          if (w_op_nxt == OP_ROR) begin
            w_ror_b7 = w_c_nxt;  // old carry rotates into bit 7
          end else begin
            w_add_sb7 = 1'b1;
          end
          if (w_dst_nxt) w_sb_db = 1'b1;
          else           w_sb_ac = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge PHI2) begin
    if (RES) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADC;
      r_dst    <= 1'b0;
      r_c      <= 1'b0;
      r_d      <= 1'b0;
      ADDSEL   <= '0;
      OPS      <= '0;
      ADD_SB06 <= 1'b0;
      ADD_SB7  <= 1'b0;
      SB_AC    <= 1'b0;
      AC_SB    <= 1'b0;
      SB_DB    <= 1'b0;
      n_ACIN   <= 1'b1;
      n_DAA    <= 1'b1;
      n_DSA    <= 1'b1;
      ROR_B7   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      C_OUT    <= 1'b0;
      V_OUT    <= 1'b0;
      FLAG_WE  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= OPSEL;
        r_dst <= DST;
        r_c   <= C_IN;
        r_d   <= D_IN;
      end
      ADDSEL   <= w_addsel;
      OPS      <= w_ops;
      ADD_SB06 <= w_add_sb06;
      ADD_SB7  <= w_add_sb7;
      SB_AC    <= w_sb_ac;
      AC_SB    <= w_ac_sb;
      SB_DB    <= w_sb_db;
      n_ACIN   <= w_n_acin;
      n_DAA    <= w_n_daa;
      n_DSA    <= w_n_dsa;
      ROR_B7   <= w_ror_b7;
      BUSY     <= (w_state_nxt != S_IDLE);
      DONE     <= w_done;
      ERR      <= w_err_nxt;
      FLAG_WE  <= w_flag_we;
      // Flags capture the ALU results on the edge that ends STORE, using the
      // command that is finishing (r_op), not one being accepted now.
      if (r_state == S_STORE) begin
        if (r_op inside {OP_ADC, OP_SBC, OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR})
          C_OUT <= ACR;
        if (r_op inside {OP_ADC, OP_SBC})
          V_OUT <= AVR;
      end
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// -----------------------------------------------------------------------------
// tb_alu_control
//   Self-checking bench for alu_control. Inputs change on the falling edge and
//   outputs are compared on the falling edge against a cycle-phase model.
// -----------------------------------------------------------------------------
module tb_alu_control;

  localparam bit TB_DEC_EN = 1'b1;

  localparam logic [3:0] ADC = 4'd0, SBC = 4'd1, AND_ = 4'd2, ORA = 4'd3,
                         EOR = 4'd4, ASL = 4'd5, LSR = 4'd6, ROL = 4'd7,
                         ROR = 4'd8, INC = 4'd9, CMP = 4'd10;

  typedef enum int {PH_IDLE, PH_LOAD, PH_DEC, PH_STORE} phase_t;

  typedef struct packed {
    logic [3:0] addsel;
    logic [4:0] ops;
    logic add_sb06, add_sb7, sb_ac, ac_sb, sb_db;
    logic n_acin, n_daa, n_dsa, ror_b7;
    logic busy, done, err, flag_we;
  } ctrl_t;

  logic       PHI2 = 1'b0;
  logic       RES, START, DST, C_IN, D_IN, ACR, AVR;
  logic [3:0] OPSEL;
  logic [3:0] ADDSEL;
  logic [4:0] OPS;
  logic ADD_SB06, ADD_SB7, SB_AC, AC_SB, SB_DB, n_ACIN, n_DAA, n_DSA, ROR_B7;
  logic BUSY, DONE, ERR, C_OUT, V_OUT, FLAG_WE;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_c = 1'b0;
  logic exp_v = 1'b0;

  alu_control #(.DEC_EN(TB_DEC_EN)) dut (
    .PHI2(PHI2), .RES(RES), .START(START), .OPSEL(OPSEL), .DST(DST),
    .C_IN(C_IN), .D_IN(D_IN), .ACR(ACR), .AVR(AVR),
    .ADDSEL(ADDSEL), .OPS(OPS), .ADD_SB06(ADD_SB06), .ADD_SB7(ADD_SB7),
    .SB_AC(SB_AC), .AC_SB(AC_SB), .SB_DB(SB_DB), .n_ACIN(n_ACIN),
    .n_DAA(n_DAA), .n_DSA(n_DSA), .ROR_B7(ROR_B7), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .C_OUT(C_OUT), .V_OUT(V_OUT), .FLAG_WE(FLAG_WE)
  );

  always #5 PHI2 = ~PHI2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  ctrl_t obs;
  assign obs = '{ADDSEL, OPS, ADD_SB06, ADD_SB7, SB_AC, AC_SB, SB_DB,
                 n_ACIN, n_DAA, n_DSA, ROR_B7, BUSY, DONE, ERR, FLAG_WE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  // What the control lines should be in a given phase of a command.
  function automatic ctrl_t model(phase_t ph, logic [3:0] op, logic dst, logic c, logic d);
    ctrl_t r;
    bit    acc_op;
    r = '0;
    r.n_acin = 1'b1;
    r.n_daa  = 1'b1;
    r.n_dsa  = 1'b1;
    if (ph == PH_IDLE) return r;
    r.busy  = 1'b1;
    r.n_daa = !(TB_DEC_EN && d && op == ADC);
    r.n_dsa = !(TB_DEC_EN && d && op == SBC);
    if (ph == PH_LOAD) begin
      acc_op   = op inside {ADC, SBC, CMP, AND_, ORA, EOR};
      r.ac_sb  = acc_op;
      r.sb_db  = !acc_op;
      r.addsel[0] = 1'b1;
      if (op inside {SBC, CMP}) r.addsel[3] = 1'b1;
      else if (op == INC)       r.addsel[1] = 1'b1;
      else                      r.addsel[2] = 1'b1;
      case (op)
        AND_:     r.ops = 5'b10000;
        EOR:      r.ops = 5'b01000;
        ORA:      r.ops = 5'b00100;
        LSR, ROR: r.ops = 5'b00010;
        default:  r.ops = 5'b00001;
      endcase
      if (op inside {ADC, SBC, ROL})  r.n_acin = !c;
      else if (op inside {CMP, INC})  r.n_acin = 1'b0;
    end else if (ph == PH_STORE) begin
      r.done    = 1'b1;
      r.flag_we = 1'b1;
      if (op != CMP) begin
        r.add_sb06 = 1'b1;
        r.add_sb7  = (op != ROR);
        r.ror_b7   = (op == ROR) ? c : 1'b0;
        r.sb_ac    = !dst;
        r.sb_db    = dst;
      end
    end
    return r;
  endfunction

  function automatic ctrl_t err_vec();
    ctrl_t r;
    r = model(PH_IDLE, ADC, 1'b0, 1'b0, 1'b0);
    r.err = 1'b1;
    return r;
  endfunction

  task automatic update_flags(input logic [3:0] op, input logic acr, input logic avr);
    if (op inside {ADC, SBC, CMP, ASL, LSR, ROL, ROR}) exp_c = acr;
    if (op inside {ADC, SBC}) exp_v = avr;
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".c_out"}, 32'(C_OUT), 32'(exp_c));
    check({tag, ".v_out"}, 32'(V_OUT), 32'(exp_v));
  endtask

  // Issue one legal command (caller sits just after a falling edge) and check
  // every cycle through the return to IDLE. ACR/AVR hold the inverse of the
  // intended values until the STORE cycle so early capture is visible.
  task automatic cmd(input logic [3:0] op, input logic dst, input logic c,
                     input logic d, input logic acr, input logic avr, input string tag);
    bit dec;
    dec   = TB_DEC_EN && d && (op == ADC || op == SBC);
    START = 1'b1; OPSEL = op; DST = dst; C_IN = c; D_IN = d;
    ACR   = ~acr; AVR = ~avr;
    @(negedge PHI2);
    START = 1'b0;
    OPSEL = 4'($urandom_range(15)); DST = 1'($urandom_range(1));
    C_IN  = 1'($urandom_range(1));  D_IN = 1'($urandom_range(1));
    check({tag, ".load"}, 32'(obs), 32'(model(PH_LOAD, op, dst, c, d)));
    if (dec) begin
      @(negedge PHI2);
      check({tag, ".decimal"}, 32'(obs), 32'(model(PH_DEC, op, dst, c, d)));
    end
    @(negedge PHI2);
    check({tag, ".store"}, 32'(obs), 32'(model(PH_STORE, op, dst, c, d)));
    ACR = acr; AVR = avr;
    update_flags(op, acr, avr);
    @(negedge PHI2);
    ACR = 1'($urandom_range(1)); AVR = 1'($urandom_range(1));
    check({tag, ".idle"}, 32'(obs), 32'(model(PH_IDLE, op, dst, c, d)));
    check_flags(tag);
  endtask

  task automatic illegal_cmd(input logic [3:0] op, input string tag);
    START = 1'b1; OPSEL = op;
    @(negedge PHI2);
    START = 1'b0;
    check({tag, ".err"}, 32'(obs), 32'(err_vec()));
    check_flags(tag);
    @(negedge PHI2);
    check({tag, ".idle"}, 32'(obs), 32'(model(PH_IDLE, ADC, 1'b0, 1'b0, 1'b0)));
  endtask

  initial begin
    RES = 1'b1; START = 1'b0; OPSEL = 4'd0; DST = 1'b0;
    C_IN = 1'b0; D_IN = 1'b0; ACR = 1'b0; AVR = 1'b0;
    repeat (2) @(negedge PHI2);
    check("reset.ctrl", 32'(obs), 32'(model(PH_IDLE, ADC, 1'b0, 1'b0, 1'b0)));
    check_flags("reset");
    RES = 1'b0;
    @(negedge PHI2);

    // ADC, carry in set, no decimal, to accumulator; ACR=0 AVR=1.
    cmd(ADC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "adc");
    // Decimal SBC: LOAD/DECIMAL/STORE with n_DSA low throughout.
    cmd(SBC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "sbc_dec");
    // ROR with carry in to the data bus.
    cmd(ROR, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "ror");
    // Illegal opcode: ERR pulse, flags untouched.
    illegal_cmd(4'd13, "illegal13");

    // CMP with START held through LOAD and STORE carrying an AND.
    START = 1'b1; OPSEL = CMP; DST = 1'b1; C_IN = 1'b0; D_IN = 1'b0;
    ACR = 1'b0; AVR = 1'b1;
    @(negedge PHI2);
    check("b2b.cmp_load", 32'(obs), 32'(model(PH_LOAD, CMP, 1'b1, 1'b0, 1'b0)));
    OPSEL = AND_; DST = 1'b0; C_IN = 1'b1;
    @(negedge PHI2);
    check("b2b.cmp_store", 32'(obs), 32'(model(PH_STORE, CMP, 1'b1, 1'b0, 1'b0)));
    ACR = 1'b1; AVR = 1'b1;
    update_flags(CMP, 1'b1, 1'b1);
    @(negedge PHI2);
    START = 1'b0; ACR = 1'b0; AVR = 1'b0;
    check("b2b.and_load", 32'(obs), 32'(model(PH_LOAD, AND_, 1'b0, 1'b1, 1'b0)));
    check_flags("b2b.cmp");
    @(negedge PHI2);
    check("b2b.and_store", 32'(obs), 32'(model(PH_STORE, AND_, 1'b0, 1'b1, 1'b0)));
    @(negedge PHI2);
    check("b2b.idle", 32'(obs), 32'(model(PH_IDLE, ADC, 1'b0, 1'b0, 1'b0)));
    check_flags("b2b.and");

    // Reset during the LOAD of an ADC after flags were set.
    cmd(ADC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "adc_set");
    START = 1'b1; OPSEL = ADC; DST = 1'b0; C_IN = 1'b1; D_IN = 1'b0;
    ACR = 1'b0; AVR = 1'b0;
    @(negedge PHI2);
    START = 1'b0; RES = 1'b1;
    @(negedge PHI2);
    RES = 1'b0;
    exp_c = 1'b0; exp_v = 1'b0;
    check("res_load.ctrl", 32'(obs), 32'(model(PH_IDLE, ADC, 1'b0, 1'b0, 1'b0)));
    check_flags("res_load");
    @(negedge PHI2);
    check("res_load.after", 32'(obs), 32'(model(PH_IDLE, ADC, 1'b0, 1'b0, 1'b0)));

    // Randomized commands, including illegal opcodes.
    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      sel = $urandom_range(11);
      if (sel == 11)
        illegal_cmd(4'($urandom_range(15, 11)), $sformatf("rnd%0d.illegal", i));
      else
        cmd(4'(sel), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            $sformatf("rnd%0d.op%0d", i, sel));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
